// File: rtl/fb_arbiter.sv
// Framebuffer RAM-port arbiter: scanout reads > clear engine (FB_CLEAR_EN) > drawing writer.
// Scan reads run 2 pixels ahead; the pixel is valid 2 cycles after the read; the writer stalls in scan slots and during a clear.
module fb_arbiter #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int HTOTAL  = 800,
  parameter int VTOTAL  = 525,
  parameter int PIX_W   = 4,
  parameter int ADDR_W  = 15,
  parameter int FB_W    = HACTIVE >> 2,
  parameter int FB_H    = VACTIVE >> 2
) (
  input  logic              vgaclk,
  input  logic              reset_b,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              blank_b,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pixel
);

  localparam int FB_SIZE = FB_W * FB_H;

  logic [10:0]       w_nx_raw;
  logic [10:0]       w_nx;
  logic [9:0]        w_ny;
  logic              w_scan_slot;
  logic [7:0]        w_row;
  logic [8:0]        w_col;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_clr_wr;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [PIX_W-1:0]  w_clr_data;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_scan_d;
  logic [PIX_W-1:0]  r_pix;

  always_comb begin
    w_nx_raw = {1'b0, x} + 11'd2;
    w_nx     = w_nx_raw;
    w_ny     = y;
    if (w_nx_raw >= 11'(HTOTAL)) begin
      w_nx = w_nx_raw - 11'(HTOTAL);
      w_ny = (y == 10'(VTOTAL - 1)) ? 10'd0 : y + 10'd1;
    end
  end

  assign w_scan_slot = (w_nx[1:0] == 2'b00) && (w_nx < 11'(HACTIVE)) && (w_ny < 10'(VACTIVE));
  assign w_row       = w_ny[9:2];
  assign w_col       = w_nx[10:2];
  // row*160 as shift-add keeps the address path free of a multiplier
  assign w_scan_addr = (ADDR_W'(w_row) << 7) + (ADDR_W'(w_row) << 5) + ADDR_W'(w_col);

`ifdef FB_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic [PIX_W-1:0]  r_clr_color;
  logic              r_done;
  logic              w_done_nxt;

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_done    <= w_done_nxt;
      if (r_state == S_IDLE && clear_req) r_clr_color <= clear_color;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_done_nxt    = 1'b0;
    w_clr_wr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (!w_scan_slot) begin
          w_clr_wr = 1'b1;
          if (r_clr_cnt == ADDR_W'(FB_SIZE - 1)) begin
            w_state_nxt   = S_IDLE;
            w_clr_cnt_nxt = '0;
            w_done_nxt    = 1'b1;
          end else begin
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_clr_addr = r_clr_cnt;
  assign w_clr_data = r_clr_color;
  assign clear_busy = (r_state == S_CLEAR);
  assign clear_done = r_done;
`else
  logic w_unused;
  assign w_unused   = ^{clear_req, clear_color};
  assign w_clr_wr   = 1'b0;
  assign w_clr_addr = '0;
  assign w_clr_data = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  // Outputs are forced to 0 while reset is held, independent of the clock.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = r_last_addr;
    ram_wdata = '0;
    wr_ready  = 1'b0;
    if (!reset_b) begin
      ram_addr = '0;
    end else begin
      wr_ready = ~w_scan_slot & ~clear_busy;
      if (w_scan_slot) begin
        ram_addr = w_scan_addr;
      end else if (w_clr_wr) begin
        ram_we    = 1'b1;
        ram_addr  = w_clr_addr;
        ram_wdata = w_clr_data;
      end else if (wr_valid && !clear_busy && wr_addr < ADDR_W'(FB_SIZE)) begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
      end
    end
  end

  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      r_last_addr <= '0;
      r_scan_d    <= 1'b0;
      r_pix       <= '0;
    end else begin
      r_last_addr <= ram_addr;
      r_scan_d    <= w_scan_slot;
      if (r_scan_d) r_pix <= ram_rdata;
    end
  end

  assign pixel = blank_b ? r_pix : '0;

endmodule
